pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline hazard and sequencing controller for the five-stage core (IF, ID, EX, MEM, WB). It watches the ID-stage decode flags and the downstream stage status, then drives per-stage stall and flush enables. It generates `ld_risk` for the ID-stage forwarding mux and sequences multi-cycle mul/div, fence drain and trap flush. Pipeline registers consume its outputs directly: stall means hold, flush means load a bubble.

## Interface
- `FENCE_DRAIN_CYC`, default 3: cycles the pipeline behind ID is drained before a fence leaves ID; equals the EX+MEM+WB depth.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_rf_raddr1`, `id_rf_raddr2` in `RF_ADDR_WIDTH`: ID source register addresses.
- `id_is_mul_inst`, `id_is_div_inst` in 1: mul/div in ID (already qualified by valid).
- `id_is_fence_inst` in 1: fence in ID.
- `id_fence_tp` in 1: fence type; 1 = fence.i.
- `ex_is_load` in 1: EX holds a load.
- `ex_req_rf` in 1: EX holds an instruction that writes the register file.
- `ex_rd_addr` in `RF_ADDR_WIDTH`: EX destination register.
- `ex_bj_taken` in 1: branch/jump in EX redirects the PC this cycle.
- `md_done` in 1: mul/div unit result valid (single-cycle pulse).
- `mem_busy` in 1: outstanding data-memory transaction.
- `wb_trap` in 1: exception, interrupt or mret committing in WB.
- `ld_risk` out 1: load-use hazard; ID must not forward from EX.
- `if_stall`, `id_stall`, `ex_stall` out 1: hold the IF, ID and EX stage registers.
- `if2id_flush`, `id2ex_flush`, `ex2mem_flush`, `mem2wb_flush` out 1: insert a bubble into that pipeline register.
- `md_start` out 1: one-cycle start pulse to the mul/div unit.
- `md_abort` out 1: one-cycle cancel pulse to the mul/div unit.
- `icache_flush` out 1: one-cycle I-cache invalidate pulse.
- `ctrl_state` out 2: FSM state, for debug.

## Operation
FSM states:
- RUN = 0
- MD_WAIT = 1
- FENCE_DRAIN = 2
- TRAP_FLUSH = 3

Priority within a cycle, highest first: `wb_trap`, then current non-RUN state, then `ex_bj_taken`, then load-use, then fence entry, then `md_start`.

Load-use hazard:
- `hz = id_valid & ex_is_load & ex_req_rf & (ex_rd_addr != 0) & (ex_rd_addr == id_rf_raddr1 | ex_rd_addr == id_rf_raddr2)`.
- `ld_risk = hz`, combinational in all states.

Behaviour by state:
- **RUN, load-use** (`hz`): `if_stall = id_stall = 1`, `id2ex_flush = 1` for one cycle. The bubble clears `hz` next cycle.
- **RUN, branch** (`ex_bj_taken`): `if2id_flush = id2ex_flush = 1`. This overrides `hz`: no stall, but `ld_risk` is still driven.
- **RUN, fence entry** (`id_is_fence_inst`, no higher event): `if_stall = id_stall = 1`, `id2ex_flush = 1`. The counter loads `FENCE_DRAIN_CYC`; next state is FENCE_DRAIN.
- **RUN, mul/div issue** (mul or div in ID, ID not stalled or flushed): `md_start = 1`. Next state is MD_WAIT; the instruction enters EX.
- **MD_WAIT, `md_done = 0`**: `if_stall = id_stall = ex_stall = 1`, `ex2mem_flush = 1`.
- **MD_WAIT, `md_done = 1`**: all stalls drop that same cycle, so the result advances to MEM. Next state is RUN.
- **FENCE_DRAIN**:
  - IF/ID stay stalled and `id2ex_flush = 1`.
  - The counter decrements only while `mem_busy = 0`; it saturates at 0.
  - When the counter is 0 and `mem_busy = 0`, this is the release cycle: stalls drop, the fence advances, and `icache_flush = id_fence_tp`. Next state is RUN.
- **TRAP_FLUSH** (entered on `wb_trap` from any state):
  - In the `wb_trap` cycle all four flushes are 1 and all stalls are 0.
  - If the current state is MD_WAIT, `md_abort = 1`.
  - Next state is TRAP_FLUSH. It holds `if2id_flush = id2ex_flush = 1` for one cycle, then goes to RUN.
  - A `wb_trap` arriving while in TRAP_FLUSH restarts that one cycle.
- Bubbles never generate `md_start`, and nothing re-enters fence from a bubble, because both paths are qualified by the valid-qualified ID flags.

## Timing
- Reset: every output is 0, `ctrl_state = RUN`, counter = 0.
- Reset asserted mid-MD_WAIT or mid-FENCE_DRAIN returns the FSM to RUN immediately; no `md_abort` is issued.
- All outputs are combinational from the state and inputs. State and counter are registered on the `clk` rising edge.
- Load-use costs 1 bubble.
- Taken branch costs 2 flushed slots.
- Mul/div costs N+1 cycles, where `md_done` arrives N cycles after `md_start`. If `md_done` arrives in the same cycle as `md_start`, the FSM still enters MD_WAIT and exits on the first `md_done` seen there. The unit must not pulse `md_done` before it has been started.
- Fence, with `mem_busy = 0` throughout: the fence is held in ID for `FENCE_DRAIN_CYC + 1` cycles, counting the entry cycle. The release cycle follows.
- Trap costs 2 cycles of flush.

## Test plan
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID → one cycle with `ld_risk = if_stall = id_stall = id2ex_flush = 1`, then normal flow. Repeat with `ex_rd_addr = 0` → no stall.
- Taken branch coinciding with `hz` → `if2id_flush = id2ex_flush = 1`, `id_stall = 0`, `ld_risk = 1`.
- Mul/div: mul in ID, `md_done` 4 cycles after `md_start` → `md_start` pulse, `ctrl_state = 1` for 4 cycles with `ex_stall = 1`, release on the `md_done` cycle. Then a back-to-back div → second `md_start` the following cycle.
- Fence.i with `mem_busy` high for 2 cycles → ID held 2 + 3 + 1 cycles, then exactly one `icache_flush` pulse on the release cycle. Same with `id_fence_tp = 0` → no `icache_flush`.
- `wb_trap` during MD_WAIT → `md_abort` and all four flushes in that cycle, `ctrl_state = 3` next cycle, RUN after that.
- `rst_n` asserted low mid-FENCE_DRAIN → all outputs 0 immediately, `ctrl_state = 0`. After release the pipeline resumes from RUN.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Status and control bundle between the five-stage core and
//               its hazard/sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int RF_ADDR_WIDTH = 5
);
  // ID-stage decode flags
  logic                     id_valid;
  logic [RF_ADDR_WIDTH-1:0] id_rf_raddr1;
  logic [RF_ADDR_WIDTH-1:0] id_rf_raddr2;
  logic                     id_is_mul_inst;
  logic                     id_is_div_inst;
  logic                     id_is_fence_inst;
  logic                     id_fence_tp;
  // Downstream stage status
  logic                     ex_is_load;
  logic                     ex_req_rf;
  logic [RF_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                     ex_bj_taken;
  logic                     md_done;
  logic                     mem_busy;
  logic                     wb_trap;
  // Controller outputs
  logic                     ld_risk;
  logic                     if_stall;
  logic                     id_stall;
  logic                     ex_stall;
  logic                     if2id_flush;
  logic                     id2ex_flush;
  logic                     ex2mem_flush;
  logic                     mem2wb_flush;
  logic                     md_start;
  logic                     md_abort;
  logic                     icache_flush;
  logic [1:0]               ctrl_state;

  // Core side: reports status, consumes stall/flush controls
  modport master (
    output id_valid, id_rf_raddr1, id_rf_raddr2, id_is_mul_inst, id_is_div_inst,
           id_is_fence_inst, id_fence_tp, ex_is_load, ex_req_rf, ex_rd_addr,
           ex_bj_taken, md_done, mem_busy, wb_trap,
    input  ld_risk, if_stall, id_stall, ex_stall, if2id_flush, id2ex_flush,
           ex2mem_flush, mem2wb_flush, md_start, md_abort, icache_flush, ctrl_state
  );

  // Controller side
  modport slave (
    input  id_valid, id_rf_raddr1, id_rf_raddr2, id_is_mul_inst, id_is_div_inst,
           id_is_fence_inst, id_fence_tp, ex_is_load, ex_req_rf, ex_rd_addr,
           ex_bj_taken, md_done, mem_busy, wb_trap,
    output ld_risk, if_stall, id_stall, ex_stall, if2id_flush, id2ex_flush,
           ex2mem_flush, mem2wb_flush, md_start, md_abort, icache_flush, ctrl_state
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Hazard and sequencing controller for the IF/ID/EX/MEM/WB
//               pipeline: load-use stall, branch flush, mul/div wait,
//               fence drain and trap flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int FENCE_DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam logic [1:0] c_st_run         = 2'd0;
  localparam logic [1:0] c_st_md_wait     = 2'd1;
  localparam logic [1:0] c_st_fence_drain = 2'd2;
  localparam logic [1:0] c_st_trap_flush  = 2'd3;

  // Counter must hold FENCE_DRAIN_CYC; keep at least one bit for a zero depth
  localparam int c_cnt_w = (FENCE_DRAIN_CYC < 1) ? 1 : $clog2(FENCE_DRAIN_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(FENCE_DRAIN_CYC);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;

  logic w_hz;
  logic w_md_req;
  logic w_drain_done;

  logic w_if_stall;
  logic w_id_stall;
  logic w_ex_stall;
  logic w_if2id_flush;
  logic w_id2ex_flush;
  logic w_ex2mem_flush;
  logic w_mem2wb_flush;
  logic w_md_start;
  logic w_md_abort;
  logic w_icache_flush;

  // Load-use: EX load writes a non-zero register that ID is about to read
  assign w_hz = bus.id_valid & bus.ex_is_load & bus.ex_req_rf &
                (bus.ex_rd_addr != '0) &
                ((bus.ex_rd_addr == bus.id_rf_raddr1) |
                 (bus.ex_rd_addr == bus.id_rf_raddr2));

  assign w_md_req     = bus.id_is_mul_inst | bus.id_is_div_inst;
  // Drain is complete once the counter is spent and memory is quiet
  assign w_drain_done = (r_cnt == '0) & ~bus.mem_busy;

  // State and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_run;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and counter; trap wins over everything, then the current mode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.wb_trap) begin
      w_state_nxt = c_st_trap_flush;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        c_st_run: begin
          if (bus.ex_bj_taken || w_hz) begin
            w_state_nxt = c_st_run;
          end else if (bus.id_is_fence_inst) begin
            w_state_nxt = c_st_fence_drain;
            w_cnt_nxt   = c_cnt_load;
          end else if (w_md_req) begin
            w_state_nxt = c_st_md_wait;
          end
        end
        c_st_md_wait: begin
          if (bus.md_done) begin
            w_state_nxt = c_st_run;
          end
        end
        c_st_fence_drain: begin
          if (w_drain_done) begin
            w_state_nxt = c_st_run;
          end else if (!bus.mem_busy && (r_cnt != '0)) begin
            // Memory traffic pauses the drain count
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        c_st_trap_flush: begin
          w_state_nxt = c_st_run;
        end
        default: begin
          w_state_nxt = c_st_run;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Stall/flush/pulse decode from the current state and this cycle's events
  always_comb begin
    w_if_stall     = 1'b0;
    w_id_stall     = 1'b0;
    w_ex_stall     = 1'b0;
    w_if2id_flush  = 1'b0;
    w_id2ex_flush  = 1'b0;
    w_ex2mem_flush = 1'b0;
    w_mem2wb_flush = 1'b0;
    w_md_start     = 1'b0;
    w_md_abort     = 1'b0;
    w_icache_flush = 1'b0;
    if (bus.wb_trap) begin
      w_if2id_flush  = 1'b1;
      w_id2ex_flush  = 1'b1;
      w_ex2mem_flush = 1'b1;
      w_mem2wb_flush = 1'b1;
      // Only an in-flight mul/div needs cancelling
      w_md_abort     = (r_state == c_st_md_wait);
    end else begin
      case (r_state)
        c_st_run: begin
          if (bus.ex_bj_taken) begin
            w_if2id_flush = 1'b1;
            w_id2ex_flush = 1'b1;
          end else if (w_hz || bus.id_is_fence_inst) begin
            // Same hold-and-bubble pattern for load-use and fence entry
            w_if_stall    = 1'b1;
            w_id_stall    = 1'b1;
            w_id2ex_flush = 1'b1;
          end else if (w_md_req) begin
            w_md_start = 1'b1;
          end
        end
        c_st_md_wait: begin
          if (!bus.md_done) begin
            w_if_stall     = 1'b1;
            w_id_stall     = 1'b1;
            w_ex_stall     = 1'b1;
            w_ex2mem_flush = 1'b1;
          end
        end
        c_st_fence_drain: begin
          if (w_drain_done) begin
            w_icache_flush = bus.id_fence_tp;
          end else begin
            w_if_stall    = 1'b1;
            w_id_stall    = 1'b1;
            w_id2ex_flush = 1'b1;
          end
        end
        c_st_trap_flush: begin
          w_if2id_flush = 1'b1;
          w_id2ex_flush = 1'b1;
        end
        default: begin
          w_if2id_flush = 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, regardless of inputs
  assign bus.ld_risk      = rst_n & w_hz;
  assign bus.if_stall     = rst_n & w_if_stall;
  assign bus.id_stall     = rst_n & w_id_stall;
  assign bus.ex_stall     = rst_n & w_ex_stall;
  assign bus.if2id_flush  = rst_n & w_if2id_flush;
  assign bus.id2ex_flush  = rst_n & w_id2ex_flush;
  assign bus.ex2mem_flush = rst_n & w_ex2mem_flush;
  assign bus.mem2wb_flush = rst_n & w_mem2wb_flush;
  assign bus.md_start     = rst_n & w_md_start;
  assign bus.md_abort     = rst_n & w_md_abort;
  assign bus.icache_flush = rst_n & w_icache_flush;
  assign bus.ctrl_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Randomized self-checking bench for pipe_ctrl against a
//               mode/count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int DRAIN = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  // Reference model: which long operation is in progress, and drain progress
  bit m_md;
  bit m_fence;
  bit m_trap;
  int m_drained;

  pipe_ctrl_if #(.RF_ADDR_WIDTH(5)) bus ();

  pipe_ctrl #(.FENCE_DRAIN_CYC(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [12:0] dut_outs();
    return {bus.ld_risk, bus.if_stall, bus.id_stall, bus.ex_stall,
            bus.if2id_flush, bus.id2ex_flush, bus.ex2mem_flush, bus.mem2wb_flush,
            bus.md_start, bus.md_abort, bus.icache_flush, bus.ctrl_state};
  endfunction

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rf_raddr1 = 0; bus.id_rf_raddr2 = 0;
    bus.id_is_mul_inst = 0; bus.id_is_div_inst = 0; bus.id_is_fence_inst = 0;
    bus.id_fence_tp = 0; bus.ex_is_load = 0; bus.ex_req_rf = 0; bus.ex_rd_addr = 0;
    bus.ex_bj_taken = 0; bus.md_done = 0; bus.mem_busy = 0; bus.wb_trap = 0;
  endtask

  task automatic random_inputs();
    bit v;
    v = ($urandom_range(0, 7) != 0);
    bus.id_valid         = v;
    bus.id_rf_raddr1     = 5'($urandom_range(0, 3));
    bus.id_rf_raddr2     = 5'($urandom_range(0, 3));
    bus.id_is_mul_inst   = v && ($urandom_range(0, 5) == 0);
    bus.id_is_div_inst   = v && ($urandom_range(0, 9) == 0);
    bus.id_is_fence_inst = v && ($urandom_range(0, 9) == 0);
    bus.id_fence_tp      = 1'($urandom_range(0, 1));
    bus.ex_is_load       = 1'($urandom_range(0, 1));
    bus.ex_req_rf        = ($urandom_range(0, 3) != 0);
    bus.ex_rd_addr       = 5'($urandom_range(0, 3));
    bus.ex_bj_taken      = ($urandom_range(0, 7) == 0);
    bus.md_done          = ($urandom_range(0, 3) == 0);
    bus.mem_busy         = ($urandom_range(0, 2) == 0);
    bus.wb_trap          = ($urandom_range(0, 24) == 0);
  endtask

  // Expected outputs for the current inputs; also advances the model one cycle
  task automatic model_step(output logic [12:0] exp);
    bit hz, ifs, ids, exs, f1, f2, f3, f4, mds, mda, icf;
    logic [1:0] st;
    hz = bus.id_valid && bus.ex_is_load && bus.ex_req_rf && (bus.ex_rd_addr != 0) &&
         (bus.ex_rd_addr == bus.id_rf_raddr1 || bus.ex_rd_addr == bus.id_rf_raddr2);
    {ifs, ids, exs, f1, f2, f3, f4, mds, mda, icf} = '0;
    st = m_trap ? 2'd3 : m_fence ? 2'd2 : m_md ? 2'd1 : 2'd0;
    if (bus.wb_trap) begin
      {f1, f2, f3, f4} = 4'hf;
      mda = m_md;
      m_trap = 1; m_md = 0; m_fence = 0;
    end else if (m_trap) begin
      f1 = 1; f2 = 1;
      m_trap = 0;
    end else if (m_md) begin
      if (bus.md_done) m_md = 0;
      else begin ifs = 1; ids = 1; exs = 1; f3 = 1; end
    end else if (m_fence) begin
      if (m_drained == DRAIN && !bus.mem_busy) begin
        icf = bus.id_fence_tp;
        m_fence = 0;
      end else begin
        ifs = 1; ids = 1; f2 = 1;
        if (!bus.mem_busy && m_drained < DRAIN) m_drained++;
      end
    end else if (bus.ex_bj_taken) begin
      f1 = 1; f2 = 1;
    end else if (hz) begin
      ifs = 1; ids = 1; f2 = 1;
    end else if (bus.id_is_fence_inst) begin
      ifs = 1; ids = 1; f2 = 1;
      m_fence = 1; m_drained = 0;
    end else if (bus.id_is_mul_inst || bus.id_is_div_inst) begin
      mds = 1;
      m_md = 1;
    end
    exp = {hz, ifs, ids, exs, f1, f2, f3, f4, mds, mda, icf, st};
  endtask

  // Inputs are applied at negedge; check shortly after, then let the edge pass
  task automatic run_cycle(input string tag);
    logic [12:0] exp;
    #1;
    model_step(exp);
    chk_eq(tag, 32'(dut_outs()), 32'(exp));
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_md = 0; m_fence = 0; m_trap = 0; m_drained = 0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    // Reset holds all outputs low even with a hazard presented
    bus.id_valid = 1; bus.ex_is_load = 1; bus.ex_req_rf = 1;
    bus.ex_rd_addr = 5'd5; bus.id_rf_raddr1 = 5'd5;
    #1;
    chk_eq("reset_outs", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      run_cycle("rand");
    end

    // Return to RUN via a trap, then start a fence.i and reset mid-drain
    clear_inputs();
    bus.wb_trap = 1;
    run_cycle("pre_trap");
    clear_inputs();
    run_cycle("pre_trap_exit");
    bus.id_valid = 1; bus.id_is_fence_inst = 1; bus.id_fence_tp = 1;
    run_cycle("fence_entry");
    run_cycle("fence_drain0");
    run_cycle("fence_drain1");
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("midfence_reset", 32'(dut_outs()), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    run_cycle("post_reset_idle");
    bus.id_valid = 1; bus.id_is_mul_inst = 1;
    run_cycle("post_reset_mul");
    bus.id_is_mul_inst = 0;
    run_cycle("post_reset_wait");
    bus.md_done = 1;
    run_cycle("post_reset_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
